// File: rtl/sccb_config_sequencer_if.sv
// Write-command channel between the table sequencer and the shared I2C master.
interface sccb_config_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_dev;
   logic [7:0] cmd_reg;
   logic [7:0] cmd_data;
   logic       xfer_done;
   logic       xfer_nack;

   modport master (
      output cmd_valid, cmd_dev, cmd_reg, cmd_data,
      input  cmd_ready, xfer_done, xfer_nack
   );

   modport slave (
      input  cmd_valid, cmd_dev, cmd_reg, cmd_data,
      output cmd_ready, xfer_done, xfer_nack
   );
endinterface

// File: rtl/sccb_config_sequencer.sv
// Camera register table walker: one SCCB write per entry, with end/delay
// markers, NACK retry with back-off and sticky done/error status.
module sccb_config_sequencer #(
   parameter logic [6:0] DEV_ADDR     = 7'h21,
   parameter int         ADDR_W       = 8,
   parameter int         DELAY_CYCLES = 1000,
   parameter int         MAX_RETRY    = 3,
   parameter int         RETRY_GAP    = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   sccb_config_sequencer_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] err_index
);
   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, ISSUE, WAIT_XFER, DELAY, GAP, DONE, ERROR
   } state_t;

   localparam int WMAX = (DELAY_CYCLES > RETRY_GAP) ? DELAY_CYCLES
                                                    : RETRY_GAP;
   localparam int CW = (WMAX > 1) ? $clog2(WMAX) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   // Load N-1 so the wait lasts N cycles; a zero parameter still waits one.
   localparam logic [CW-1:0] D_LOAD =
      CW'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);
   localparam logic [CW-1:0] G_LOAD =
      CW'((RETRY_GAP > 0) ? RETRY_GAP - 1 : 0);
   localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);

   localparam logic [15:0] END_MARK = 16'hFFFF;
   localparam logic [15:0] DLY_MARK = 16'hFFF0;

   state_t            state, nstate;
   logic [ADDR_W-1:0] index;
   logic [RW-1:0]     retry;
   logic [CW-1:0]     wait_cnt;
   logic              idle_like, last, ack, nack;
   logic              wait_over, adv, can_retry;

   assign idle_like = (state == IDLE) || (state == DONE) ||
                      (state == ERROR);
   assign last      = &index;
   assign ack       = (state == WAIT_XFER) && bus.xfer_done &&
                      !bus.xfer_nack;
   assign nack      = (state == WAIT_XFER) && bus.xfer_done &&
                      bus.xfer_nack;
   assign wait_over = (wait_cnt == '0);
   assign adv       = ack || ((state == DELAY) && wait_over);
   assign can_retry = (retry < R_MAX);
   assign rom_addr  = index;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE, DONE, ERROR: if (start) nstate = FETCH;
         FETCH:             nstate = DECODE;
         DECODE: begin
            unique case (1'b1)
               (rom_data == END_MARK): nstate = DONE;
               (rom_data == DLY_MARK): nstate = DELAY;
               default:                nstate = ISSUE;
            endcase
         end
         ISSUE:     if (bus.cmd_ready) nstate = WAIT_XFER;
         WAIT_XFER: begin
            if (adv)       nstate = last ? DONE : FETCH;
            else if (nack) nstate = can_retry ? GAP : ERROR;
         end
         DELAY:     if (adv) nstate = last ? DONE : FETCH;
         GAP:       if (wait_over) nstate = ISSUE;
         default:   nstate = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_valid = (state == ISSUE);
      busy          = !idle_like;
      done          = (state == DONE);
      error         = (state == ERROR);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         index        <= '0;
         retry        <= '0;
         wait_cnt     <= '0;
         err_index    <= '0;
         bus.cmd_dev  <= '0;
         bus.cmd_reg  <= '0;
         bus.cmd_data <= '0;
      end else begin
         if (idle_like && start)
            index <= '0;
         else if (adv && !last)
            index <= index + ADDR_W'(1);

         if (state == DECODE) begin
            if (rom_data == DLY_MARK) begin
               wait_cnt <= D_LOAD;
            end else if (rom_data != END_MARK) begin
               bus.cmd_dev  <= DEV_ADDR;
               bus.cmd_reg  <= rom_data[15:8];
               bus.cmd_data <= rom_data[7:0];
               retry        <= '0;
            end
         end else if (nack) begin
            if (can_retry) begin
               retry    <= retry + RW'(1);
               wait_cnt <= G_LOAD;
            end else begin
               err_index <= index;
            end
         end else if ((state == DELAY || state == GAP) && !wait_over) begin
            wait_cnt <= wait_cnt - CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench for sccb_config_sequencer: table walks, NACK retry,
// delay marker, stalled master, no-wrap and mid-transfer reset.
module tb_sccb_config_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        busy, done, error;
   logic [7:0]  err_index;
   logic [15:0] rom [256];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int nack_first = 0;
   int nack_idx   = -1;
   int nack_base  = 0;
   int pend       = 0;
   logic nack_now = 1'b0;
   int iss_reg[$], iss_data[$], iss_dev[$], iss_idx[$], iss_cyc[$];
   int done_cyc[$];

   int base, dbase, lat, r, d, stable, bad, cnt5, g;

   sccb_config_sequencer_if bus();

   sccb_config_sequencer #(
      .DEV_ADDR(7'h21), .ADDR_W(8), .DELAY_CYCLES(1000),
      .MAX_RETRY(3), .RETRY_GAP(64)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .bus(bus.master),
      .busy(busy), .done(done), .error(error),
      .err_index(err_index)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rom_data <= rom[rom_addr];
   end

   // I2C master model: accepts on valid & ready, reports 2 cycles later.
   always @(negedge clk) begin
      bus.xfer_done = 1'b0;
      bus.xfer_nack = 1'b0;
      if (!rst) begin
         pend = 0;
      end else begin
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.xfer_done = 1'b1;
               bus.xfer_nack = nack_now;
               done_cyc.push_back(cyc);
            end
         end
         if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
            nack_now = (int'(rom_addr) == nack_idx) ||
                       (iss_reg.size() - nack_base < nack_first);
            iss_reg.push_back(int'(bus.cmd_reg));
            iss_data.push_back(int'(bus.cmd_data));
            iss_dev.push_back(int'(bus.cmd_dev));
            iss_idx.push_back(int'(rom_addr));
            iss_cyc.push_back(cyc);
            pend = 2;
         end
      end
   end

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [15:0] v);
      for (int i = 0; i < 256; i++) rom[i] = v;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_ready = 1'b1;
      fill(16'hFFFF);
      repeat (3) @(negedge clk);

      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_cmd_valid", bus.cmd_valid, 0);
      chk("rst_cmd_dev", bus.cmd_dev, 0);
      chk("rst_cmd_reg", bus.cmd_reg, 0);
      chk("rst_cmd_data", bus.cmd_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_err_index", err_index, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // T1: two writes then end marker
      rom[0] = 16'h1280;
      rom[1] = 16'h1101;
      rom[2] = 16'hFFFF;
      base = iss_reg.size();
      lat  = 0;
      @(negedge clk);
      start = 1'b1;
      do begin
         @(negedge clk);
         start = 1'b0;
         lat++;
      end while (bus.cmd_valid !== 1'b1 && lat < 20);
      chk("t1_latency", lat, 3);
      wait_idle("t1", 200);
      chk("t1_count", iss_reg.size() - base, 2);
      chk("t1_dev0", q_at(iss_dev, base), 32'h21);
      chk("t1_reg0", q_at(iss_reg, base), 32'h12);
      chk("t1_data0", q_at(iss_data, base), 32'h80);
      chk("t1_reg1", q_at(iss_reg, base + 1), 32'h11);
      chk("t1_data1", q_at(iss_data, base + 1), 32'h01);
      chk("t1_done", done, 1);
      chk("t1_error", error, 0);

      // T2: two NACKs then ACK on the same entry
      fill(16'hFFFF);
      rom[0] = 16'h3A04;
      base = iss_reg.size();
      nack_base  = base;
      nack_first = 2;
      pulse_start();
      wait_idle("t2", 1000);
      nack_first = 0;
      chk("t2_count", iss_reg.size() - base, 3);
      g = q_at(iss_cyc, base + 1) - q_at(iss_cyc, base);
      chk("t2_gap1", g >= 64, 1);
      g = q_at(iss_cyc, base + 2) - q_at(iss_cyc, base + 1);
      chk("t2_gap2", g >= 64, 1);
      chk("t2_reg2", q_at(iss_reg, base + 2), 32'h3A);
      chk("t2_data2", q_at(iss_data, base + 2), 32'h04);
      chk("t2_done", done, 1);
      chk("t2_error", error, 0);

      // T3: entry 5 never ACKs
      fill(16'hFFFF);
      for (int i = 0; i < 5; i++) rom[i] = 16'h1000 + 16'(i);
      rom[5] = 16'h5555;
      base = iss_reg.size();
      nack_idx = 5;
      pulse_start();
      wait_idle("t3", 2000);
      nack_idx = -1;
      cnt5 = 0;
      for (int i = base; i < iss_idx.size(); i++)
         if (iss_idx[i] == 5) cnt5++;
      chk("t3_count", iss_reg.size() - base, 9);
      chk("t3_issues_idx5", cnt5, 4);
      chk("t3_error", error, 1);
      chk("t3_err_index", err_index, 5);
      chk("t3_done", done, 0);

      // T4: delay marker between two writes
      fill(16'hFFFF);
      rom[0] = 16'h1280;
      rom[1] = 16'hFFF0;
      rom[2] = 16'h1101;
      rom[3] = 16'hFFFF;
      base  = iss_reg.size();
      dbase = done_cyc.size();
      pulse_start();
      chk("t4_error_cleared", error, 0);
      chk("t4_busy", busy, 1);
      wait_idle("t4", 3000);
      chk("t4_count", iss_reg.size() - base, 2);
      chk("t4_reg1", q_at(iss_reg, base + 1), 32'h11);
      g = q_at(iss_cyc, base + 1) - q_at(done_cyc, dbase);
      chk("t4_delay", g >= 1000, 1);
      chk("t4_done", done, 1);

      // T5: stalled master, ignored start, full table without end marker
      for (int i = 0; i < 256; i++) rom[i] = {8'(i), 8'h5A};
      bus.cmd_ready = 1'b0;
      base = iss_reg.size();
      pulse_start();
      lat = 0;
      while (bus.cmd_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("t5_valid", bus.cmd_valid, 1);
      r = int'(bus.cmd_reg);
      d = int'(bus.cmd_data);
      stable = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         start = (k == 10);
         if (bus.cmd_valid !== 1'b1 || int'(bus.cmd_reg) != r ||
             int'(bus.cmd_data) != d)
            stable = 0;
      end
      start = 1'b0;
      chk("t5_hold", stable, 1);
      chk("t5_hold_reg", r, 32'h00);
      chk("t5_hold_data", d, 32'h5A);
      bus.cmd_ready = 1'b1;
      wait_idle("t5", 5000);
      chk("t5_count", iss_reg.size() - base, 256);
      chk("t5_last_reg", q_at(iss_reg, iss_reg.size() - 1), 32'hFF);
      bad = 0;
      for (int i = base; i < iss_idx.size(); i++)
         if (iss_idx[i] != i - base) bad++;
      chk("t5_order", bad, 0);
      chk("t5_rom_addr_end", rom_addr, 255);
      chk("t5_done", done, 1);

      // T6: reset while waiting for the transfer result
      fill(16'hFFFF);
      rom[0] = 16'h1280;
      base = iss_reg.size();
      pulse_start();
      lat = 0;
      while (iss_reg.size() == base && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("t6_accepted", iss_reg.size() - base, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("t6_cmd_valid", bus.cmd_valid, 0);
      chk("t6_cmd_reg", bus.cmd_reg, 0);
      chk("t6_cmd_data", bus.cmd_data, 0);
      chk("t6_cmd_dev", bus.cmd_dev, 0);
      chk("t6_busy", busy, 0);
      chk("t6_rom_addr", rom_addr, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      base = iss_reg.size();
      pulse_start();
      wait_idle("t6", 200);
      chk("t6_rerun_count", iss_reg.size() - base, 1);
      chk("t6_rerun_idx", q_at(iss_idx, base), 0);
      chk("t6_rerun_reg", q_at(iss_reg, base), 32'h12);
      chk("t6_done", done, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
